// File: rtl/gshare_mt.sv
// gshare_mt: multi-thread gshare branch direction predictor.
// One shared PHT of saturating counters, one global history per thread,
// and a self-timed sequential PHT clear.
module gshare_mt #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned HIST_W  = 7,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned THREADS = 2,
  localparam int unsigned TID_W  = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              predict_valid,
  input  logic [TID_W-1:0]  predict_tid,
  input  logic [PC_W-1:0]   predict_pc,
  output logic              predict_taken,
  output logic [HIST_W-1:0] predict_history,
  input  logic              train_valid,
  input  logic [TID_W-1:0]  train_tid,
  input  logic              train_taken,
  input  logic              train_mispredicted,
  input  logic [HIST_W-1:0] train_history,
  input  logic [PC_W-1:0]   train_pc,
  input  logic              clear_req,
  output logic              busy
);

  localparam int unsigned       ENTRIES = 1 << PC_W;
  localparam logic [CTR_W-1:0]  WNT     = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0]  CTR_MAX = '1;
  localparam logic [CTR_W-1:0]  CTR_MIN = '0;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   ptr;
  logic [CTR_W-1:0]  pht  [ENTRIES];
  logic [HIST_W-1:0] hist [THREADS];

  logic [HIST_W-1:0] pred_hist;
  logic [PC_W-1:0]   pred_idx;
  logic [CTR_W-1:0]  pred_ctr;
  logic [PC_W-1:0]   tr_idx;
  logic [CTR_W-1:0]  tr_ctr;
  logic [CTR_W-1:0]  tr_ctr_nxt;
  logic              start_clear;

  // Index: history XORed into the low bits, upper PC bits pass through.
  function automatic logic [PC_W-1:0] idx_of(input logic [PC_W-1:0]   pc,
                                             input logic [HIST_W-1:0] h);
    logic [PC_W-1:0] ext;
    ext = '0;
    ext[HIST_W-1:0] = h;
    return pc ^ ext;
  endfunction

  // Select the requesting thread's history (loop keeps non-power-of-two safe).
  always_comb begin
    pred_hist = '0;
    for (int unsigned t = 0; t < THREADS; t++) begin
      if (predict_tid == TID_W'(t)) pred_hist = hist[t];
    end
  end

  assign pred_idx        = idx_of(predict_pc, pred_hist);
  assign pred_ctr        = pht[pred_idx];
  assign predict_history = pred_hist;
  assign predict_taken   = (state == IDLE) && pred_ctr[CTR_W-1];
  assign busy            = (state == CLEAR);

  // Saturating counter update for the resolved branch.
  always_comb begin
    tr_idx     = idx_of(train_pc, train_history);
    tr_ctr     = pht[tr_idx];
    tr_ctr_nxt = tr_ctr;
    if (train_taken) begin
      if (tr_ctr != CTR_MAX) tr_ctr_nxt = tr_ctr + 1'b1;
    end else begin
      if (tr_ctr != CTR_MIN) tr_ctr_nxt = tr_ctr - 1'b1;
    end
  end

  // Clear FSM next-state: leave CLEAR after the last entry is written.
  always_comb begin
    state_nxt   = state;
    start_clear = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt   = CLEAR;
          start_clear = 1'b1;
        end
      end
      CLEAR: begin
        if (ptr == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM state and sweep pointer.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (start_clear)          ptr <= '0;
      else if (state == CLEAR)  ptr <= ptr + 1'b1;
    end
  end

  // Per-thread history: mispredict recovery beats the speculative shift.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned t = 0; t < THREADS; t++) hist[t] <= '0;
    end else if (start_clear) begin
      for (int unsigned t = 0; t < THREADS; t++) hist[t] <= '0;
    end else if (state == IDLE) begin
      for (int unsigned t = 0; t < THREADS; t++) begin
        if (train_valid && train_mispredicted && (train_tid == TID_W'(t)))
          hist[t] <= HIST_W'({train_history, train_taken});
        else if (predict_valid && (predict_tid == TID_W'(t)))
          hist[t] <= HIST_W'({hist[t], predict_taken});
      end
    end
  end

  // PHT: clear sweep owns the table while busy, otherwise train updates.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) pht[i] <= WNT;
    end else if (state == CLEAR) begin
      pht[ptr] <= WNT;
    end else if (train_valid) begin
      pht[tr_idx] <= tr_ctr_nxt;
    end
  end

endmodule

// File: tb/tb_gshare_mt.sv
// Directed self-checking bench for gshare_mt at default parameters.
module tb_gshare_mt;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       predict_valid;
  logic [0:0] predict_tid;
  logic [6:0] predict_pc;
  logic       predict_taken;
  logic [6:0] predict_history;
  logic       train_valid;
  logic [0:0] train_tid;
  logic       train_taken;
  logic       train_mispredicted;
  logic [6:0] train_history;
  logic [6:0] train_pc;
  logic       clear_req;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;
  logic pt_bad;

  gshare_mt #(.PC_W(7), .HIST_W(7), .CTR_W(2), .THREADS(2)) dut (
    .clk                (clk),
    .areset_n           (areset_n),
    .predict_valid      (predict_valid),
    .predict_tid        (predict_tid),
    .predict_pc         (predict_pc),
    .predict_taken      (predict_taken),
    .predict_history    (predict_history),
    .train_valid        (train_valid),
    .train_tid          (train_tid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_history      (train_history),
    .train_pc           (train_pc),
    .clear_req          (clear_req),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_train(input logic v, input logic [6:0] pc, input logic [6:0] h,
                           input logic tk, input logic mp, input logic tid);
    train_valid        = v;
    train_pc           = pc;
    train_history      = h;
    train_taken        = tk;
    train_mispredicted = mp;
    train_tid          = tid;
  endtask

  task automatic set_pred(input logic v, input logic tid, input logic [6:0] pc);
    predict_valid = v;
    predict_tid   = tid;
    predict_pc    = pc;
  endtask

  initial begin
    areset_n  = 1'b1;
    clear_req = 1'b0;
    set_train(0, 7'h00, 7'h00, 0, 0, 0);
    set_pred(0, 0, 7'h0a);

    // Reset asserted mid-cycle
    #2 areset_n = 1'b0;
    #1;
    chk("rst_taken", predict_taken, 1'b0);
    chk("rst_hist_t0", predict_history, 7'h00);
    chk("rst_busy", busy, 1'b0);
    predict_tid = 1;
    #1;
    chk("rst_hist_t1", predict_history, 7'h00);
    predict_tid = 0;
    #10 areset_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    // Training pht[0x0a]: 01 -> 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00
    set_train(1, 7'h0a, 7'h00, 1, 0, 0);
    tick();
    set_train(0, 7'h0a, 7'h00, 1, 0, 0);
    #1;
    chk("train_ctr10", predict_taken, 1'b1);
    set_train(1, 7'h0a, 7'h00, 1, 0, 0);
    tick();
    tick();
    chk("train_ctr11", predict_taken, 1'b1);
    set_train(1, 7'h0a, 7'h00, 0, 0, 0);
    tick();
    chk("train_nt1_ctr10", predict_taken, 1'b1);
    tick();
    chk("train_nt2_ctr01", predict_taken, 1'b0);
    tick();
    tick();
    set_train(0, 7'h0a, 7'h00, 0, 0, 0);
    #1;
    chk("train_ctr00", predict_taken, 1'b0);

    // Prepare entries 0x0a (00->10), 0x0b (01->10), 0x09 (01->10)
    set_train(1, 7'h0a, 7'h00, 1, 0, 0);
    tick();
    tick();
    set_train(1, 7'h0b, 7'h00, 1, 0, 0);
    tick();
    set_train(1, 7'h09, 7'h00, 1, 0, 0);
    tick();
    set_train(0, 7'h00, 7'h00, 0, 0, 0);

    // Thread isolation: tid0 shifts taken three times
    set_pred(1, 0, 7'h0a);
    #1;
    chk("iso_pt0", predict_taken, 1'b1);
    tick();
    chk("iso_hist01", predict_history, 7'h01);
    chk("iso_pt1", predict_taken, 1'b1);
    tick();
    chk("iso_hist03", predict_history, 7'h03);
    chk("iso_pt2", predict_taken, 1'b1);
    tick();
    chk("iso_hist07", predict_history, 7'h07);
    set_pred(0, 1, 7'h0a);
    #1;
    chk("iso_hist_t1", predict_history, 7'h00);

    // Recovery on tid1 vs predict on tid1: recovery wins
    set_train(1, 7'h40, 7'h10, 0, 1, 1);
    set_pred(1, 1, 7'h0a);
    #1;
    chk("rec_old_hist_t1", predict_history, 7'h00);
    tick();
    chk("rec_hist_t1", predict_history, 7'h20);
    // Recovery on tid1 and predict on tid0 in the same cycle
    set_pred(1, 0, 7'h0a);
    #1;
    chk("rec_pt_t0", predict_taken, 1'b0);
    chk("rec_old_hist_t0", predict_history, 7'h07);
    tick();
    set_train(0, 7'h00, 7'h00, 0, 0, 0);
    set_pred(0, 0, 7'h0a);
    #1;
    chk("rec_hist_t0", predict_history, 7'h0e);
    predict_tid = 1;
    #1;
    chk("rec_hist_t1_kept", predict_history, 7'h20);

    // Saturate pht[0x0a] (10 -> 11), then clear with trains/predicts during busy
    set_train(1, 7'h0a, 7'h00, 1, 0, 0);
    tick();
    clear_req = 1'b1;
    set_pred(1, 0, 7'h0a);
    tick();
    clear_req   = 1'b0;
    busy_cycles = 0;
    pt_bad      = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      busy_cycles++;
      if (predict_taken !== 1'b0) pt_bad = 1'b1;
      clear_req = (i == 10);
      tick();
    end
    clear_req = 1'b0;
    set_train(0, 7'h00, 7'h00, 0, 0, 0);
    set_pred(0, 0, 7'h0a);
    #1;
    chk("clr_busy_cycles", busy_cycles, 128);
    chk("clr_pt_zero_busy", pt_bad, 1'b0);
    chk("clr_busy_low", busy, 1'b0);
    chk("clr_pt_wnt", predict_taken, 1'b0);
    chk("clr_hist_t0", predict_history, 7'h00);
    predict_tid = 1;
    #1;
    chk("clr_hist_t1", predict_history, 7'h00);
    predict_tid = 0;

    // Same-entry collision: predict sees pre-update counter
    set_train(1, 7'h0a, 7'h00, 1, 0, 0);
    set_pred(1, 0, 7'h0a);
    #1;
    chk("col_pt_same", predict_taken, 1'b0);
    tick();
    set_train(0, 7'h00, 7'h00, 0, 0, 0);
    set_pred(0, 0, 7'h0a);
    #1;
    chk("col_pt_next", predict_taken, 1'b1);
    chk("col_hist", predict_history, 7'h00);

    // Saturate pht[0x7f], then reset in the middle of a clear
    set_train(1, 7'h7f, 7'h00, 1, 0, 0);
    tick();
    tick();
    set_train(0, 7'h00, 7'h00, 0, 0, 0);
    predict_pc = 7'h7f;
    #1;
    chk("mid_pre_pt7f", predict_taken, 1'b1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("mid_busy", busy, 1'b1);
    areset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pt", predict_taken, 1'b0);
    chk("mid_rst_hist", predict_history, 7'h00);
    #2 areset_n = 1'b1;
    tick();
    chk("mid_post_busy", busy, 1'b0);
    chk("mid_post_pt7f", predict_taken, 1'b0);
    predict_pc = 7'h0a;
    #1;
    chk("mid_post_pt0a", predict_taken, 1'b0);
    tick();
    chk("mid_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
